// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed 7-segment driver for DIGITS hex digits.
// Each digit is lit for SCAN_DIV clocks. Loaded values are double-buffered so
// the displayed set only changes on a frame boundary.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module seg_scan_display #(
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_done
);

    localparam int TW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);

    logic [TW-1:0]         tick_r;
    logic [IW-1:0]         idx_r;
    logic                  pend_r;
    logic [4*DIGITS-1:0]   act_data_r;
    logic [DIGITS-1:0]     act_dp_r;
    logic [DIGITS-1:0]     act_blank_r;
    logic [4*DIGITS-1:0]   pnd_data_r;
    logic [DIGITS-1:0]     pnd_dp_r;
    logic [DIGITS-1:0]     pnd_blank_r;
    logic [6:0]            seg_r;
    logic                  dp_r;
    logic [DIGITS-1:0]     dig_r;
    logic                  frame_done_r;

    logic                  tick_last_s;
    logic                  boundary_s;
    logic [DIGITS-1:0]     lz_s;
    logic [DIGITS-1:0]     eff_blank_s;
    logic [DIGITS-1:0]     hit_s;
    logic [6:0]            seg_s;
    logic                  dp_s;

    // Hex font, active-low segments g..a.
    function automatic logic [6:0] font(input logic [3:0] nib);
        case (nib)
            4'h0:    font = 7'h40;
            4'h1:    font = 7'h79;
            4'h2:    font = 7'h24;
            4'h3:    font = 7'h30;
            4'h4:    font = 7'h19;
            4'h5:    font = 7'h12;
            4'h6:    font = 7'h02;
            4'h7:    font = 7'h78;
            4'h8:    font = 7'h00;
            4'h9:    font = 7'h10;
            4'hA:    font = 7'h08;
            4'hB:    font = 7'h03;
            4'hC:    font = 7'h46;
            4'hD:    font = 7'h21;
            4'hE:    font = 7'h06;
            4'hF:    font = 7'h0E;
            default: font = 7'h7F;
        endcase
    endfunction

    assign tick_last_s = (tick_r == TW'(SCAN_DIV - 1));
    assign boundary_s  = tick_last_s && (idx_r == IW'(DIGITS - 1));

    // Scan counters: tick within a digit slot, idx selects the digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_r <= '0;
            idx_r  <= '0;
        end else if (tick_last_s) begin
            tick_r <= '0;
            // Any code at or above the last digit (including unused codes) wraps to 0.
            idx_r  <= (idx_r >= IW'(DIGITS - 1)) ? '0 : idx_r + IW'(1);
        end else begin
            tick_r <= tick_r + TW'(1);
        end
    end

    // Double buffer: loads go to pending, promoted to active only at a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r      <= 1'b0;
            act_data_r  <= '0;
            act_dp_r    <= '0;
            act_blank_r <= '1;
            pnd_data_r  <= '0;
            pnd_dp_r    <= '0;
            pnd_blank_r <= '1;
        end else if (boundary_s) begin
            pend_r <= 1'b0;
            if (load) begin
                // A load in the boundary cycle goes straight to active.
                act_data_r  <= data_in;
                act_dp_r    <= dp_in;
                act_blank_r <= blank_in;
            end else if (pend_r) begin
                act_data_r  <= pnd_data_r;
                act_dp_r    <= pnd_dp_r;
                act_blank_r <= pnd_blank_r;
            end else begin
                act_data_r  <= act_data_r;
                act_dp_r    <= act_dp_r;
                act_blank_r <= act_blank_r;
            end
        end else if (load) begin
            pend_r      <= 1'b1;
            pnd_data_r  <= data_in;
            pnd_dp_r    <= dp_in;
            pnd_blank_r <= blank_in;
        end else begin
            pend_r      <= pend_r;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Leading-zero suppression from the top digit down; digit 0 is never suppressed.
    always_comb begin
        logic run;
        lz_s = '0;
        run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run     = run & (act_data_r[4*i +: 4] == 4'h0) & ~act_dp_r[i];
            lz_s[i] = run;
        end
    end
`else
    assign lz_s = '0;
`endif

    assign eff_blank_s = act_blank_r | lz_s;

    // Decode the currently selected digit; at most one hit, blanked or unused idx gives dark.
    always_comb begin
        hit_s = '0;
        seg_s = 7'h7F;
        dp_s  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            hit_s[i] = (idx_r == IW'(i)) && !eff_blank_s[i];
            seg_s    = seg_s & (hit_s[i] ? font(act_data_r[4*i +: 4]) : 7'h7F);
            dp_s     = dp_s & (hit_s[i] ? ~act_dp_r[i] : 1'b1);
        end
    end

    // Registered pin drivers and frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            dig_r        <= '0;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_s;
            dp_r         <= dp_s;
            dig_r        <= hit_s;
            frame_done_r <= boundary_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign dig        = dig_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_display.sv
// Testbench for seg_scan_display (DIGITS=6, SCAN_DIV=4): directed scenarios
// followed by randomized loads/resets, checked every cycle against a
// frame-level reference model driven by elapsed cycle count.
module tb_seg_scan_display;

    localparam int DIGITS   = 6;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic                clk;
    logic                rst;
    logic [4*DIGITS-1:0] data_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic                load;
    logic [6:0]          seg;
    logic                dp;
    logic [DIGITS-1:0]   dig;
    logic                frame_done;

    seg_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .dig        (dig),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int test_cnt = 0;
    int fail_cnt = 0;

    logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: displayed set, waiting set, cycles since reset.
    logic [4*DIGITS-1:0] m_data, m_pdata;
    logic [DIGITS-1:0]   m_dp, m_pdp, m_blank, m_pblank;
    bit                  m_pend;
    int                  cyc;
    logic [6:0]          e_seg;
    logic                e_dp;
    logic [DIGITS-1:0]   e_dig;
    logic                e_fd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_dark(input int i);
        bit lz;
        lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (i != 0) begin
            lz = 1'b1;
            for (int j = i; j < DIGITS; j++)
                if (((m_data >> (4*j)) & 24'hF) != 0 || m_dp[j]) lz = 1'b0;
        end
`endif
        return m_blank[i] | lz;
    endfunction

    task automatic step();
        int i;
        bit bnd;
        @(posedge clk);
        if (rst) begin
            m_data = '0; m_dp = '0; m_blank = '1; m_pend = 0;
            cyc = 0;
            e_seg = 7'h7F; e_dp = 1'b1; e_dig = '0; e_fd = 1'b0;
        end else begin
            i   = (cyc / SCAN_DIV) % DIGITS;
            bnd = (cyc % FRAME) == FRAME - 1;
            if (is_dark(i)) begin
                e_seg = 7'h7F; e_dp = 1'b1; e_dig = '0;
            end else begin
                e_seg = font_tab[(m_data >> (4*i)) & 24'hF];
                e_dp  = ~m_dp[i];
                e_dig = DIGITS'(1) << i;
            end
            e_fd = bnd;
            if (bnd) begin
                if (load) begin
                    m_data = data_in; m_dp = dp_in; m_blank = blank_in;
                end else if (m_pend) begin
                    m_data = m_pdata; m_dp = m_pdp; m_blank = m_pblank;
                end
                m_pend = 0;
            end else if (load) begin
                m_pdata = data_in; m_pdp = dp_in; m_pblank = blank_in; m_pend = 1;
            end
            cyc++;
        end
        #1;
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("dig", 32'(dig), 32'(e_dig));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic do_load(input logic [23:0] d, input logic [5:0] p, input logic [5:0] b);
        data_in = d; dp_in = p; blank_in = b; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Advance until the next edge is at frame position pos.
    task automatic wait_pos(input int pos);
        while ((cyc % FRAME) != pos) step();
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0;
        cyc = 0;
        step(); step();
        rst = 1'b0;
        repeat (2 * FRAME) step();                     // dark, frame_done every 24
        do_load(24'h12AB3F, 6'b0, 6'b0);
        repeat (2 * FRAME + 10) step();
        wait_pos(10);
        do_load(24'h000000, 6'b0, 6'b0);
        step();
        do_load(24'h999999, 6'b0, 6'b0);               // last load wins
        repeat (2 * FRAME) step();
        wait_pos(FRAME - 1);
        do_load(24'h555555, 6'b0, 6'b0);               // boundary bypass
        repeat (FRAME + 6) step();
        do_load(24'hABCDEF, 6'b000101, 6'b000100);
        repeat (2 * FRAME) step();
        do_load(24'h000120, 6'b0, 6'b0);
        repeat (2 * FRAME) step();
        do_load(24'h000000, 6'b0, 6'b0);
        repeat (2 * FRAME) step();
        do_load(24'h876543, 6'b010000, 6'b0);
        repeat (2 * FRAME) step();
        wait_pos(7);
        do_load(24'h111111, 6'b0, 6'b0);               // pending load discarded by reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2 * FRAME) step();
        // Randomized loads, blanking and occasional resets
        for (int n = 0; n < 600; n++) begin
            load     = ($urandom_range(7) == 0);
            data_in  = 24'($urandom);
            dp_in    = 6'($urandom);
            blank_in = ($urandom_range(3) == 0) ? 6'($urandom) : 6'b0;
            if ($urandom_range(3) == 0) data_in = data_in & 24'h000FFF;
            if ($urandom_range(3) == 0) dp_in = 6'b0;
            rst      = ($urandom_range(149) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0;
        repeat (FRAME) step();
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
